// File: rtl/cu_pkg.sv
// Shared types for the multi-cycle LEGv8 control unit: FSM states,
// ALU function codes, control-word layout and opcode decode helpers.
package cu_pkg;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_ILL, OP_ADD, OP_SUB,
    OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
    OP_MOVZ, OP_LDUR, OP_STUR
  } op_e;

  typedef enum logic [1:0] {
    IMM_NONE, IMM_ZX12, IMM_SX9, IMM_MOV16
  } imm_e;

  localparam logic [4:0] FS_ADD    = 5'b00010;
  localparam logic [4:0] FS_SUB    = 5'b00101;
  localparam logic [4:0] FS_PASS_B = 5'b01100;

  // Offsets above the three register-address fields
  localparam int CW_FS     = 0;
  localparam int CW_BSEL   = 5;
  localparam int CW_REGWR  = 6;
  localparam int CW_MEMWR  = 7;
  localparam int CW_MEMRD  = 8;
  localparam int CW_STLD   = 9;
  localparam int CW_DSEL   = 10;
  localparam int CW_CTRL_W = 11;

  typedef struct packed {
    logic       d_sel;
    logic       status_ld;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       b_sel;
    logic [4:0] fs;
  } ctrl_t;

  localparam logic [10:0] OPC_ADD   = 11'h458;
  localparam logic [10:0] OPC_SUB   = 11'h658;
  localparam logic [10:0] OPC_LDUR  = 11'h7C2;
  localparam logic [10:0] OPC_STUR  = 11'h7C0;
  localparam logic [9:0]  OPC_ADDI  = 10'h244;
  localparam logic [9:0]  OPC_ADDIS = 10'h2C4;
  localparam logic [9:0]  OPC_SUBI  = 10'h344;
  localparam logic [9:0]  OPC_SUBIS = 10'h3C4;
  localparam logic [8:0]  OPC_MOVZ  = 9'h1A5;

  function automatic op_e decode_op(
    input logic [10:0] opc
  );
    op_e op;
    unique case (1'b1)
      opc == OPC_ADD:        op = OP_ADD;
      opc == OPC_SUB:        op = OP_SUB;
      opc == OPC_LDUR:       op = OP_LDUR;
      opc == OPC_STUR:       op = OP_STUR;
      opc[10:1] == OPC_ADDI:  op = OP_ADDI;
      opc[10:1] == OPC_ADDIS: op = OP_ADDIS;
      opc[10:1] == OPC_SUBI:  op = OP_SUBI;
      opc[10:1] == OPC_SUBIS: op = OP_SUBIS;
      opc[10:2] == OPC_MOVZ:  op = OP_MOVZ;
      default:               op = OP_ILL;
    endcase
    return op;
  endfunction

  function automatic imm_e imm_kind(input op_e op);
    imm_e k;
    unique case (op)
      OP_ADDI, OP_ADDIS,
      OP_SUBI, OP_SUBIS: k = IMM_ZX12;
      OP_MOVZ:           k = IMM_MOV16;
      OP_LDUR, OP_STUR:  k = IMM_SX9;
      default:           k = IMM_NONE;
    endcase
    return k;
  endfunction

  function automatic logic is_sform(input op_e op);
    return (op == OP_ADDIS) || (op == OP_SUBIS);
  endfunction

  function automatic logic is_mem(input op_e op);
    return (op == OP_LDUR) || (op == OP_STUR);
  endfunction

endpackage

// File: rtl/imm_extend.sv
// Constant generator: zero-extended imm12, sign-extended imm9 and
// shifted MOVZ imm16, with a range flag for shifts past DATA_W.
module imm_extend
  import cu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [17:0]       fld_i,
  input  imm_e              kind_i,
  output logic [DATA_W-1:0] imm_o,
  output logic              range_err_o
);

  // fld_i holds instruction bits [22:5]
  logic [6:0] sh;

  assign sh = {1'b0, fld_i[17:16], 4'b0000};

  always_comb begin
    imm_o       = '0;
    range_err_o = 1'b0;
    unique case (kind_i)
      IMM_ZX12: imm_o = DATA_W'(fld_i[16:5]);
      IMM_SX9: begin
        imm_o = {{(DATA_W-9){fld_i[15]}},
                 fld_i[15:7]};
      end
      IMM_MOV16: begin
        imm_o = DATA_W'(fld_i[15:0]) << sh;
        range_err_o =
          ({25'd0, sh} >= 32'(DATA_W));
      end
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer.
// Define ILLEGAL_TRAP_EN to halt with a sticky trap on illegal opcodes.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int RA_W   = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            I,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [3:0]             flags,
  output logic [3:0]             status,
  output logic [DATA_W-1:0]      constant,
  output logic [11+3*RA_W-1:0]   CW,
  output logic                   illegal,
  output logic                   trap
);

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] const_q, const_d;
  logic [3:0]        status_q, status_d;
  logic [DATA_W-1:0] ext;
  logic              ext_err;
  op_e               op;
  imm_e              kind;
  logic              bad_op;
  ctrl_t             base, ctl;
  logic [RA_W-1:0]   da, sa, sb;
  logic              cw_en;

  assign op     = decode_op(ir_q[31:21]);
  assign kind   = imm_kind(op);
  assign bad_op = (op == OP_ILL) ||
                  ((op == OP_MOVZ) && ext_err);

  imm_extend #(
    .DATA_W (DATA_W)
  ) u_ext (
    .fld_i       (ir_q[22:5]),
    .kind_i      (kind),
    .imm_o       (ext),
    .range_err_o (ext_err)
  );

  // Per-opcode function select and register fields
  always_comb begin
    base = '0;
    da   = RA_W'(ir_q[4:0]);
    sa   = RA_W'(ir_q[9:5]);
    sb   = '0;
    unique case (op)
      OP_ADD: begin
        base.fs = FS_ADD;
        sb      = RA_W'(ir_q[20:16]);
      end
      OP_SUB: begin
        base.fs = FS_SUB;
        sb      = RA_W'(ir_q[20:16]);
      end
      OP_ADDI, OP_ADDIS: begin
        base.fs    = FS_ADD;
        base.b_sel = 1'b1;
      end
      OP_SUBI, OP_SUBIS: begin
        base.fs    = FS_SUB;
        base.b_sel = 1'b1;
      end
      OP_MOVZ: begin
        base.fs    = FS_PASS_B;
        base.b_sel = 1'b1;
        sa         = '0;
      end
      OP_LDUR, OP_STUR: begin
        base.fs    = FS_ADD;
        base.b_sel = 1'b1;
        sb         = RA_W'(ir_q[4:0]);
      end
      default: begin
        da = '0;
        sa = '0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    const_d  = const_q;
    status_d = status_q;
    i_ready  = 1'b0;
    illegal  = 1'b0;
    constant = const_q;
    cw_en    = 1'b0;
    ctl      = '0;
    // Reset masks outputs so no write strobe leaks
    if (!reset) begin
      unique case (state_q)
        FETCH: begin
          i_ready = 1'b1;
          if (i_valid) begin
            ir_d    = I;
            state_d = DECODE;
          end
        end
        DECODE: begin
          cw_en    = 1'b1;
          ctl      = base;
          constant = ext;
          const_d  = ext;
          if (bad_op) begin
            illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            state_d = HALT;
`else
            state_d = FETCH;
`endif
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          cw_en = 1'b1;
          ctl   = base;
          if (is_mem(op)) begin
            state_d = MEM;
          end else begin
            ctl.reg_wr = 1'b1;
            if (is_sform(op)) begin
              ctl.status_ld = 1'b1;
              status_d      = flags;
            end
            state_d = FETCH;
          end
        end
        MEM: begin
          cw_en = 1'b1;
          ctl   = base;
          if (op == OP_STUR) begin
            ctl.mem_wr = 1'b1;
            state_d    = FETCH;
          end else begin
            ctl.mem_rd = 1'b1;
            state_d    = WB;
          end
        end
        WB: begin
          cw_en      = 1'b1;
          ctl        = base;
          ctl.reg_wr = 1'b1;
          ctl.d_sel  = 1'b1;
          state_d    = FETCH;
        end
`ifdef ILLEGAL_TRAP_EN
        HALT: state_d = HALT;
`endif
        default: state_d = FETCH;
      endcase
    end
  end

  assign CW     = cw_en ? {ctl, sb, sa, da} : '0;
  assign status = status_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= FETCH;
      ir_q     <= '0;
      const_q  <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      const_q  <= const_d;
      status_q <= status_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic trap_q, trap_d;

  assign trap_d = trap_q | illegal;
  assign trap   = trap_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: driver queues expected
// per-cycle control words, a monitor checks them from each accept.
module tb_multicycle_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] I;
  logic        i_valid;
  logic        i_ready;
  logic [3:0]  flags;
  logic [3:0]  status;
  logic [63:0] constant;
  logic [25:0] CW;
  logic        illegal;
  logic        trap;

  logic        r32_ready;
  logic [3:0]  r32_status;
  logic [31:0] r32_const;
  logic [25:0] r32_cw;
  logic        r32_ill;
  logic        r32_trap;

  always #5 clock = ~clock;

  multicycle_control_unit #(
    .DATA_W (64),
    .RA_W   (5)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .I        (I),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .flags    (flags),
    .status   (status),
    .constant (constant),
    .CW       (CW),
    .illegal  (illegal),
    .trap     (trap)
  );

  multicycle_control_unit #(
    .DATA_W (32),
    .RA_W   (5)
  ) dut32 (
    .clock    (clock),
    .reset    (reset),
    .I        (I),
    .i_valid  (i_valid),
    .i_ready  (r32_ready),
    .flags    (flags),
    .status   (r32_status),
    .constant (r32_const),
    .CW       (r32_cw),
    .illegal  (r32_ill),
    .trap     (r32_trap)
  );

  typedef struct {
    logic [31:0]       ins;
    int                lat;
    logic [4:1][25:0]  cw;
    logic [63:0]       cst;
    logic              ill;
    logic [3:0]        st;
  } exp_t;

  localparam logic [4:0] F_ADD = 5'b00010;
  localparam logic [4:0] F_SUB = 5'b00101;
  localparam logic [4:0] F_PB  = 5'b01100;

  localparam int K_ALU = 0;
  localparam int K_ALS = 1;
  localparam int K_LD  = 2;
  localparam int K_ST  = 3;
  localparam int K_ILL = 4;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b1;
  bit         mon_busy = 1'b0;
  bit         skip = 1'b0;
  logic [3:0] st_m = 4'h0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [25:0] mk(
    bit dsel, bit sld, bit mrd, bit mwr,
    bit rw, bit bsel, logic [4:0] fs,
    logic [4:0] rb, logic [4:0] ra,
    logic [4:0] rd);
    return {dsel, sld, mrd, mwr, rw, bsel,
            fs, rb, ra, rd};
  endfunction

  task automatic send(input exp_t e,
                      input logic [3:0] fl);
    int n;
    sb_q.push_back(e);
    I       = e.ins;
    i_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!i_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!i_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ins %h",
               e.ins);
    end
    @(posedge clock);
    #1;
    flags   = fl;
    i_valid = 1'b0;
    I       = 32'hDEAD_BEEF;
  endtask

  task automatic go(input logic [31:0] ins,
                    input int kind,
                    input logic [4:0] fs,
                    input bit bsel,
                    input logic [4:0] rb,
                    input logic [4:0] ra,
                    input logic [4:0] rd,
                    input logic [63:0] cst,
                    input logic [3:0] fl);
    exp_t e;
    logic [25:0] b;
    b = mk(0, 0, 0, 0, 0, bsel, fs, rb, ra, rd);
    e.ins = ins;
    e.cw  = '0;
    e.cst = cst;
    e.ill = 1'b0;
    e.cw[1] = b;
    case (kind)
      K_ALU: begin
        e.lat = 3;
        e.cw[2] = b | mk(0,0,0,0,1,0,0,0,0,0);
      end
      K_ALS: begin
        e.lat = 3;
        e.cw[2] = b | mk(0,1,0,0,1,0,0,0,0,0);
        st_m = fl;
      end
      K_LD: begin
        e.lat = 5;
        e.cw[2] = b;
        e.cw[3] = b | mk(0,0,1,0,0,0,0,0,0,0);
        e.cw[4] = b | mk(1,0,0,0,1,0,0,0,0,0);
      end
      K_ST: begin
        e.lat = 4;
        e.cw[2] = b;
        e.cw[3] = b | mk(0,0,0,1,0,0,0,0,0,0);
      end
      default: begin
        e.lat = 2;
        e.cw[1] = '0;
        e.ill = 1'b1;
      end
    endcase
    e.st = st_m;
    send(e, fl);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Monitor: walks one instruction from its accept cycle
  initial begin : monitor
    exp_t e;
    forever begin
      if (!skip) @(negedge clock);
      skip = 1'b0;
      if (mon_en && i_valid && i_ready) begin
        mon_busy = 1'b1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept: %h", I);
        end else begin
          e = sb_q.pop_front();
          for (int k = 1; k < e.lat; k++) begin
            @(negedge clock);
            chk($sformatf("cw[%0d] %h", k, e.ins),
                64'(CW), 64'(e.cw[k]));
            chk("busy_ready", 64'(i_ready), 64'd0);
            chk("illegal", 64'(illegal),
                (k == 1) ? 64'(e.ill) : 64'd0);
            if (k == 1)
              chk("const_decode", constant, e.cst);
          end
          @(negedge clock);
          chk("ready_return", 64'(i_ready), 64'd1);
          chk("status", 64'(status), 64'(e.st));
          chk("const_hold", constant, e.cst);
          chk("cw_fetch", 64'(CW), 64'd0);
          skip = 1'b1;
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int n;
    reset   = 1'b1;
    I       = '0;
    i_valid = 1'b0;
    flags   = 4'h0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", 64'(i_ready), 64'd1);
    chk("rst_cw", 64'(CW), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_const", constant, 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_trap", 64'(trap), 64'd0);
    chk("rst32_ready", 64'(r32_ready), 64'd1);
    chk("rst32_cw", 64'(r32_cw), 64'd0);
    chk("rst32_const", 64'(r32_const), 64'd0);
    chk("rst32_status", 64'(r32_status), 64'd0);
    chk("rst32_trap", 64'(r32_trap), 64'd0);

    go(32'h910193E4, K_ALU, F_ADD, 1, 0, 31, 4,
       64'd100, 4'b0000);
    go(32'hD2803208, K_ALU, F_PB, 1, 0, 0, 8,
       64'd400, 4'b0000);
    go(32'hD2E03208, K_ALU, F_PB, 1, 0, 0, 8,
       64'h0190_0000_0000_0000, 4'b0000);
    go(32'hB100A041, K_ALS, F_ADD, 1, 0, 2, 1,
       64'd40, 4'b0101);
    go(32'h910193E4, K_ALU, F_ADD, 1, 0, 31, 4,
       64'd100, 4'b1010);
    go(32'hF10004E6, K_ALS, F_SUB, 1, 0, 7, 6,
       64'd1, 4'b1000);
    go(32'h8B0B0149, K_ALU, F_ADD, 0, 11, 10, 9,
       64'd0, 4'b1111);
    go(32'hCB0E01AC, K_ALU, F_SUB, 0, 14, 13, 12,
       64'd0, 4'b0110);
    go(32'hF85F80A3, K_LD, F_ADD, 1, 3, 5, 3,
       64'hFFFF_FFFF_FFFF_FFF8, 4'b0011);
    go(32'hF80100A3, K_ST, F_ADD, 1, 3, 5, 3,
       64'd16, 4'b1100);
`ifndef ILLEGAL_TRAP_EN
    go(32'h0000_0000, K_ILL, 5'd0, 0, 0, 0, 0,
       64'd0, 4'b0000);
`endif

    n = 0;
    while ((sb_q.size() != 0 || mon_busy) &&
           n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("scoreboard_drained",
        64'(sb_q.size()), 64'd0);
    mon_en = 1'b0;

`ifdef ILLEGAL_TRAP_EN
    pulse_reset();
    I       = 32'h0000_0000;
    i_valid = 1'b1;
    @(posedge clock);
    #1 i_valid = 1'b0;
    @(negedge clock);
    chk("trap_illegal", 64'(illegal), 64'd1);
    @(negedge clock);
    chk("trap_set", 64'(trap), 64'd1);
    chk("trap_ready", 64'(i_ready), 64'd0);
    chk("trap_pulse", 64'(illegal), 64'd0);
    repeat (3) @(negedge clock);
    chk("halt_ready", 64'(i_ready), 64'd0);
    chk("halt_cw", 64'(CW), 64'd0);
    chk("halt_trap", 64'(trap), 64'd1);
`else
    chk("trap_tied", 64'(trap), 64'd0);
`endif

    // MOVZ hw=2: legal at 64 bits, out of range at 32
    pulse_reset();
    I       = 32'hD2C03208;
    i_valid = 1'b1;
    @(posedge clock);
    #1 i_valid = 1'b0;
    @(negedge clock);
    chk("movz32_illegal", 64'(r32_ill), 64'd1);
    chk("movz64_legal", 64'(illegal), 64'd0);
    chk("movz64_const", constant,
        64'h0000_0190_0000_0000);

    // Reset in MEM of STUR cancels the store
    pulse_reset();
    I       = 32'hF80100A3;
    i_valid = 1'b1;
    @(posedge clock);
    #1 i_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_mem_cw", 64'(CW), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_mem_ready", 64'(i_ready), 64'd1);
    chk("rst_mem_cw_after", 64'(CW), 64'd0);
    chk("rst_mem_status", 64'(status), 64'd0);
    chk("rst_mem_const", constant, 64'd0);
    chk("rst_mem_trap", 64'(trap), 64'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
